// File: rtl/apb_pkg.sv
// Shared APB definitions: default bus widths, FSM states and wait-state limits.
package apb_pkg;

  localparam int APB_ADDRWIDTH = 8;
  localparam int APB_DATAWIDTH = 32;

  // Largest number of wait states the 4-bit counter can express.
  localparam int WAIT_MAX = 15;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  // Clamp a requested wait-state count into the counter's range.
  function automatic logic [3:0] clamp_wait(input int w);
    if (w > WAIT_MAX) return 4'(WAIT_MAX);
    if (w < 0)        return 4'd0;
    return 4'(w);
  endfunction

endpackage

// File: rtl/apb_mem_slave_if.sv
// APB3 bus bundle between a requester (master) and a completer (slave).
interface apb_mem_slave_if #(
  parameter int ADDRWIDTH = apb_pkg::APB_ADDRWIDTH,
  parameter int DATAWIDTH = apb_pkg::APB_DATAWIDTH
) ();

  logic [ADDRWIDTH-1:0] paddr;
  logic [DATAWIDTH-1:0] pwdata;
  logic                 psel;
  logic                 penable;
  logic                 pwrite;
  logic [DATAWIDTH-1:0] prdata;
  logic                 pready;

  modport master (
    output paddr, pwdata, psel, penable, pwrite,
    input  prdata, pready
  );

  modport slave (
    input  paddr, pwdata, psel, penable, pwrite,
    output prdata, pready
  );

endinterface

// File: rtl/apb_mem_slave.sv
// APB3 completer backed by a word-addressed register memory, with a fixed
// number of wait states per transfer and registered prdata/pready.
module apb_mem_slave
  import apb_pkg::*;
#(
  parameter int ADDRWIDTH   = APB_ADDRWIDTH,
  parameter int DATAWIDTH   = APB_DATAWIDTH,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 1
) (
  input  logic           clk,
  input  logic           rst,
  apb_mem_slave_if.slave bus
);

  localparam int                 IDXW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]         WAIT_LD = clamp_wait(WAIT_CYCLES);
  localparam logic [ADDRWIDTH:0] DEPTH_L = (ADDRWIDTH + 1)'(DEPTH);

  apb_state_e           state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [ADDRWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d;
  logic                 write_q, write_d;
  logic [DATAWIDTH-1:0] prdata_q, prdata_d;
  logic                 pready_q, pready_d;
  logic                 mem_we;

  logic [DATAWIDTH-1:0] mem [DEPTH];

  logic            in_range;
  logic [IDXW-1:0] idx;

  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign idx      = addr_q[IDXW-1:0];

  // Next-state, transfer capture and completion decode.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    write_d  = write_q;
    prdata_d = prdata_q;
    pready_d = 1'b0;
    mem_we   = 1'b0;

    unique case (state_q)
      IDLE: begin
        // Setup phase: latch the whole request; later bus changes are ignored.
        if (bus.psel && !bus.penable) begin
          state_d = ACCESS;
          addr_d  = bus.paddr;
          wdata_d = bus.pwdata;
          write_d = bus.pwrite;
          cnt_d   = WAIT_LD;
        end
      end
      ACCESS: begin
        if (!bus.psel) begin
          // Requester abort: drop the transfer silently.
          state_d = IDLE;
        end else if (cnt_q != 4'd0) begin
          // Only decremented when non-zero, so the counter saturates at 0.
          cnt_d = cnt_q - 4'd1;
        end else if (bus.penable) begin
          state_d  = IDLE;
          pready_d = 1'b1;
          if (write_q) begin
            mem_we = in_range;
          end else begin
            prdata_d = in_range ? mem[idx] : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, output and memory registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values and the update order does not matter.
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      write_q  <= 1'b0;
      prdata_q <= '0;
      pready_q <= 1'b0;
      // NOTE: the memory is cleared on reset because every word must read as
      // zero afterwards; this keeps it in flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      write_q  <= write_d;
      prdata_q <= prdata_d;
      pready_q <= pready_d;
      if (mem_we) mem[idx] <= wdata_q;
    end
  end

  assign bus.prdata = prdata_q;
  assign bus.pready = pready_q;

endmodule
